// File: rtl/pwm_generator.sv
// pwm_generator: sixteen registered output pins, each forced low, held high,
// or driven by one shared 256-step PWM waveform. The duty cycle is shadowed
// and only reloaded at the period boundary, so register writes never glitch
// the outputs mid-period.
module pwm_generator #(
    parameter int PRESCALE   = 13,
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PS_ONE  = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] r_prescale_cnt;
    logic [7:0]            r_pwm_cnt;
    logic [7:0]            r_duty_active;
    logic [15:0]           r_out;
    logic                  r_period_start;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_pwm_level;
    logic [15:0]           w_en_out;
    logic [15:0]           w_en_pwm;
    logic [15:0]           w_pin_next;

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // One PWM step every PRESCALE clocks; with PRESCALE=1 this is every clock.
    assign w_tick = (r_prescale_cnt == PS_LAST);
    // Last step of the period: the edge that wraps pwm_cnt and reloads the duty.
    assign w_wrap = w_tick && (r_pwm_cnt == 8'hFF);

    // Prescaler: count 0..PRESCALE-1 and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale_cnt <= '0;
        end else if (w_tick) begin
            r_prescale_cnt <= '0;
        end else begin
            r_prescale_cnt <= r_prescale_cnt + PS_ONE;
        end
    end

    // Step counter: advances on each tick, wraps naturally from 255 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= 8'h00;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Duty shadow: take the requested duty only on the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_active <= 8'h00;
        end else if (w_wrap) begin
            r_duty_active <= pwm_duty_cycle;
        end
    end

    // Shared PWM level; 0xFF is special-cased so full duty never drops a tick.
    always_comb begin
        w_pwm_level = 1'b0;
        if (r_duty_active == 8'hFF) begin
            w_pwm_level = 1'b1;
        end else begin
            w_pwm_level = (r_pwm_cnt < r_duty_active);
        end
    end

    // Pin mux: disabled -> 0, enabled static -> 1, enabled PWM -> shared level.
    always_comb begin
        w_pin_next = w_en_out & (~w_en_pwm | {16{w_pwm_level}});
    end

    // Output register plus the one-clock period marker following the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= 16'h0000;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_pin_next;
            r_period_start <= w_wrap;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed checks of pwm_generator with PRESCALE=1 and
// PRESCALE=2 instances sharing one set of register inputs.
module tb_pwm_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  en_out_lo;
    logic [7:0]  en_out_hi;
    logic [7:0]  en_pwm_lo;
    logic [7:0]  en_pwm_hi;
    logic [7:0]  duty;
    logic [15:0] out_p1;
    logic [15:0] out_p2;
    logic        ps_p1;
    logic        ps_p2;

    int n_checks = 0;
    int n_errors = 0;

    int          hi;
    int          first_lo;
    int          ps_at;
    logic [15:0] or_acc;
    logic [15:0] and_acc;

    int          lat1;
    int          lat2;
    logic [15:0] or1;
    logic [15:0] or2;
    bit          seen1;
    bit          seen2;

    always #5 clk = ~clk;

    pwm_generator #(.PRESCALE(1), .PRESCALE_W(16)) u_dut_p1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .out             (out_p1),
        .period_start    (ps_p1)
    );

    pwm_generator #(.PRESCALE(2), .PRESCALE_W(16)) u_dut_p2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .out             (out_p2),
        .period_start    (ps_p2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {en_out_hi, en_out_lo} = eo;
        {en_pwm_hi, en_pwm_lo} = ep;
    endtask

    function automatic logic [15:0] dout(input bit p2);
        return p2 ? out_p2 : out_p1;
    endfunction

    function automatic logic dps(input bit p2);
        return p2 ? ps_p2 : ps_p1;
    endfunction

    // Advance until the selected instance shows period_start, within a budget.
    task automatic wait_ps(input bit p2, input int limit, input string tag);
        int  c;
        bit  seen;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < limit) begin
            step();
            c++;
            seen = dps(p2);
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Sample n cycles; optionally rewrite the duty input after sample chg_at.
    task automatic window(input bit p2, input int n, input int chg_at, input logic [7:0] chg_val,
                          output int w_hi, output int w_first_lo, output int w_ps_at,
                          output logic [15:0] w_or, output logic [15:0] w_and);
        logic [15:0] o;
        w_hi       = 0;
        w_first_lo = 0;
        w_ps_at    = 0;
        w_or       = 16'h0000;
        w_and      = 16'hFFFF;
        for (int k = 1; k <= n; k++) begin
            step();
            o = dout(p2);
            if (o[0]) w_hi++;
            else if (w_first_lo == 0) w_first_lo = k;
            if (dps(p2)) w_ps_at = k;
            w_or  = w_or | o;
            w_and = w_and & o;
            if (k == chg_at) duty = chg_val;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_en(16'h0000, 16'h0000);
        duty  = 8'h00;

        // Reset state
        repeat (3) step();
        chk("rst_out_p1", 32'(out_p1), 32'h0);
        chk("rst_out_p2", 32'(out_p2), 32'h0);
        chk("rst_ps_p1", 32'(ps_p1), 32'h0);
        set_en(16'hFFFF, 16'h0000);
        step();
        chk("rst_hold_out", 32'(out_p1), 32'h0);

        // Static modes
        rst_n = 1'b1;
        step();
        chk("static_ffff_p1", 32'(out_p1), 32'hFFFF);
        chk("static_ffff_p2", 32'(out_p2), 32'hFFFF);
        set_en(16'h00F0, 16'h0000);
        chk("en_registered", 32'(out_p1), 32'hFFFF);
        step();
        chk("static_00f0", 32'(out_p1), 32'h00F0);
        set_en(16'hFFFF, 16'hFFFF);
        step();
        chk("pwm_duty0_post_rst", 32'(out_p1), 32'h0);

        // 50% duty on PRESCALE=2
        duty = 8'h80;
        wait_ps(1'b1, 1200, "d80_sync");
        window(1'b1, 512, 0, 8'h00, hi, first_lo, ps_at, or_acc, and_acc);
        chk("d80_hi", 32'(hi), 32'd256);
        chk("d80_first_lo", 32'(first_lo), 32'd257);
        chk("d80_period", 32'(ps_at), 32'd512);
        chk("d80_or", 32'(or_acc), 32'hFFFF);

        // Extremes on PRESCALE=1
        duty = 8'h00;
        wait_ps(1'b0, 600, "d00_sync");
        window(1'b0, 256, 0, 8'h00, hi, first_lo, ps_at, or_acc, and_acc);
        chk("d00_or", 32'(or_acc), 32'h0);
        chk("d00_period", 32'(ps_at), 32'd256);

        duty = 8'hFF;
        wait_ps(1'b0, 600, "dff_sync");
        window(1'b0, 300, 0, 8'h00, hi, first_lo, ps_at, or_acc, and_acc);
        chk("dff_and", 32'(and_acc), 32'hFFFF);
        chk("dff_no_dropout", 32'(first_lo), 32'd0);

        duty = 8'h01;
        wait_ps(1'b0, 600, "d01_sync");
        window(1'b0, 256, 0, 8'h00, hi, first_lo, ps_at, or_acc, and_acc);
        chk("d01_hi", 32'(hi), 32'd1);
        chk("d01_first_lo", 32'(first_lo), 32'd2);

        // Mid-period duty change
        duty = 8'h40;
        wait_ps(1'b0, 600, "mid_sync");
        window(1'b0, 256, 32, 8'hC0, hi, first_lo, ps_at, or_acc, and_acc);
        chk("mid_cur_hi", 32'(hi), 32'd64);
        chk("mid_cur_period", 32'(ps_at), 32'd256);
        window(1'b0, 256, 0, 8'h00, hi, first_lo, ps_at, or_acc, and_acc);
        chk("mid_next_hi", 32'(hi), 32'd192);
        chk("mid_next_first_lo", 32'(first_lo), 32'd193);

        // Mixed pins
        set_en(16'h0F0F, 16'h0303);
        duty = 8'h80;
        wait_ps(1'b0, 600, "mix_sync");
        window(1'b0, 256, 0, 8'h00, hi, first_lo, ps_at, or_acc, and_acc);
        chk("mix_or", 32'(or_acc), 32'h0F0F);
        chk("mix_and", 32'(and_acc), 32'h0C0C);
        chk("mix_hi", 32'(hi), 32'd128);

        // Asynchronous reset mid-period
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'hFF;
        wait_ps(1'b0, 600, "arst_sync");
        repeat (8'h90) step();
        chk("arst_pre", 32'(out_p1), 32'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_p1", 32'(out_p1), 32'h0);
        chk("arst_out_p2", 32'(out_p2), 32'h0);
        chk("arst_ps_p1", 32'(ps_p1), 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        fork
            begin
                lat1  = 0;
                seen1 = 1'b0;
                or1   = 16'h0000;
                while (!seen1 && lat1 < 300) begin
                    step();
                    lat1++;
                    seen1 = ps_p1;
                    if (!seen1) or1 = or1 | out_p1;
                end
            end
            begin
                lat2  = 0;
                seen2 = 1'b0;
                or2   = 16'h0000;
                while (!seen2 && lat2 < 600) begin
                    step();
                    lat2++;
                    seen2 = ps_p2;
                    if (!seen2) or2 = or2 | out_p2;
                end
            end
        join
        chk("arst_lat_p1", 32'(lat1), 32'd256);
        chk("arst_low_p1", 32'(or1), 32'h0);
        chk("arst_lat_p2", 32'(lat2), 32'd512);
        chk("arst_low_p2", 32'(or2), 32'h0);
        step();
        chk("arst_reload_p2", 32'(out_p2), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
Consumes the configuration registers written over SPI: output enables, PWM-mode enables and the 8-bit duty cycle. Drives 16 registered output pins. Each pin is forced low, held static high, or driven by a shared 256-step PWM waveform. Duty-cycle updates are double-buffered and take effect only at a period boundary, so SPI writes never cause glitches.

Parameters:
PRESCALE, 13, system clocks per PWM step; legal range is 1 to 65535. With clk = 10 MHz this gives a PWM frequency of about 3 kHz.
PRESCALE_W, 16, width of the prescaler counter; must satisfy 2^PRESCALE_W >= PRESCALE.

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst_n  input  1  asynchronous, active-low reset
en_reg_out_7_0  input  8  output enable for out[7:0]; 1 = pin active
en_reg_out_15_8  input  8  output enable for out[15:8]
en_reg_pwm_7_0  input  8  PWM select for out[7:0]; 1 = PWM, 0 = static high
en_reg_pwm_15_8  input  8  PWM select for out[15:8]
pwm_duty_cycle  input  8  requested duty cycle, 0x00 to 0xFF
out  output  16  registered pin outputs
period_start  output  1  one-clock pulse marking the start of each PWM period

Behaviour:
- Reset (async, rst_n low): prescale_cnt=0, pwm_cnt=0, duty_active=0x00, out=16'h0000, period_start=0. Reset mid-period clears everything immediately. After release, the first period starts from pwm_cnt=0 with duty_active=0x00.
- Prescaler:
  - prescale_cnt counts 0..PRESCALE-1 and wraps.
  - tick = (prescale_cnt == PRESCALE-1), combinational.
  - With PRESCALE=1, tick is high every cycle.
- Step counter: pwm_cnt is 8 bits and increments on tick only. It wraps 255 to 0, so one period = 256 ticks = 256*PRESCALE clocks.
- Duty shadow register:
  - duty_active <= pwm_duty_cycle on the clock edge where tick && pwm_cnt==255, i.e. the same edge on which pwm_cnt becomes 0.
  - At all other times duty_active holds, so mid-period changes to pwm_duty_cycle have no effect until the next boundary.
  - The pwm_duty_cycle sample taken at that edge is the one used.
- PWM level (combinational):
  - pwm_level = 1 if duty_active==0xFF; otherwise pwm_level = (pwm_cnt < duty_active).
  - Duty 0x00 gives constant low. Duty N (1 to 254) gives N high ticks then 256-N low ticks per period. Duty 0xFF gives constant high, with no one-tick dropout.
- Pin mux, per bit i, registered into out[i] every clock:
  - en_out[i]==0: 0.
  - en_out[i]==1 and en_pwm[i]==0: 1.
  - en_out[i]==1 and en_pwm[i]==1: pwm_level.
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
- Enable changes are not shadowed. They are visible on out one clock after the input changes.
- Latency: out reflects the pwm_cnt/duty_active state of the previous cycle (one register stage).
- period_start:
  - Registered; high for exactly one clock.
  - Asserted in the cycle immediately after the wrap edge (pwm_cnt==0 and duty_active freshly loaded).
  - Never asserted during reset. With PRESCALE=1 it still pulses once per 256 clocks.
- All 16 PWM pins share one counter and therefore switch on the same clock edge; there is no phase offset.

Test Plan:
- Reset and static modes: hold rst_n=0, check out=0x0000. Release; set en_out=0xFFFF, en_pwm=0x0000 → out=0xFFFF one clock later. Set en_out=0x00F0 → out=0x00F0.
- Duty 50%: PRESCALE=2, en_out=en_pwm=0xFFFF, write duty=0x80 → from the second period on, each pin is high 256 clocks then low 256 clocks; period_start pulses every 512 clocks.
- Extremes (PRESCALE=1, all pins PWM):
  - Duty 0x00 → out stays 0x0000 for a full period.
  - Duty 0xFF → out stays 0xFFFF for a full period with no low cycle at the wrap.
  - Duty 0x01 → exactly 1 high clock per 256.
- Mid-period update: duty=0x40 active; change to 0xC0 when pwm_cnt=0x20 → the current period still shows 64 high ticks; the next period shows 192.
- Mixed pins: en_out=0x0F0F, en_pwm=0x0303, duty=0x80 → bits 0-1 and 8-9 toggle in PWM, bits 2-3 and 10-11 are static high, and all other bits are 0.
- Async reset mid-period: assert rst_n low at pwm_cnt=0x90 between clock edges → out=0 immediately. After release, the first period_start occurs 256*PRESCALE clocks later, and the output stays low until a new duty is loaded at that boundary.
